// File: rtl/pll_lock_monitor.sv
// Multi-channel PLL lock supervisor: synchronizes raw lock flags, tracks each
// channel through acquire/lock/loss with a lock timeout, and counts lock errors.
module pll_lock_monitor #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned ERR_CNT_W    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             pll_lock,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic                          clr,
    output logic [NUM_CH-1:0]             lock_sync,
    output logic [NUM_CH-1:0]             ch_locked,
    output logic [NUM_CH-1:0]             ch_fail,
    output logic                          all_locked,
    output logic                          err_any,
    output logic [NUM_CH*ERR_CNT_W-1:0]   err_cnt
);

    localparam int unsigned          TMR_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LOCKED,
        ST_LOST,
        ST_FAIL
    } state_t;

    logic [NUM_CH-1:0][SYNC_STAGES-1:0] r_sync;
    logic [NUM_CH-1:0]                  r_prev;
    logic [NUM_CH-1:0]                  r_en;
    logic [NUM_CH-1:0]                  w_rise;
    logic [NUM_CH-1:0]                  w_fall;
    logic [NUM_CH-1:0]                  w_err_nz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= '0;
            r_en   <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], pll_lock[i]};
            end
            r_prev <= lock_sync;
            r_en   <= ch_en;
        end
    end

    assign w_rise = lock_sync & ~r_prev;
    assign w_fall = ~lock_sync & r_prev;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t               r_state;
        logic [TMR_W-1:0]     r_timer;
        logic [ERR_CNT_W-1:0] r_err;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_timer <= '0;
                r_err   <= '0;
            end else begin
                if (!ch_en[gi]) begin
                    r_state <= ST_IDLE;
                    r_timer <= '0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            r_state <= ST_WAIT;
                            r_timer <= '0;
                        end
                        ST_WAIT, ST_LOST: begin
                            // A rise on the expiry cycle still counts as a lock.
                            if (w_rise[gi]) begin
                                r_state <= ST_LOCKED;
                            end else if (r_timer == TMR_LAST) begin
                                if (clr) begin
                                    r_state <= ST_WAIT;
                                    r_timer <= '0;
                                end else begin
                                    r_state <= ST_FAIL;
                                    if (r_err != ERR_MAX) r_err <= r_err + 1'b1;
                                end
                            end else begin
                                r_timer <= r_timer + 1'b1;
                            end
                        end
                        ST_LOCKED: begin
                            if (w_fall[gi]) begin
                                r_state <= ST_LOST;
                                r_timer <= '0;
                                if (r_err != ERR_MAX) r_err <= r_err + 1'b1;
                            end
                        end
                        ST_FAIL: begin
                            if (clr) begin
                                r_state <= ST_WAIT;
                                r_timer <= '0;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_timer <= '0;
                        end
                    endcase
                end
                // Clear is last so it overrides any increment above.
                if (clr) r_err <= '0;
            end
        end

        assign lock_sync[gi]                      = r_sync[gi][SYNC_STAGES-1];
        assign ch_locked[gi]                      = (r_state == ST_LOCKED);
        assign ch_fail[gi]                        = (r_state == ST_FAIL);
        assign err_cnt[gi*ERR_CNT_W +: ERR_CNT_W] = r_err;
        assign w_err_nz[gi]                       = |r_err;
    end

    assign all_locked = (|r_en) & (&(ch_locked | ~r_en));
    assign err_any    = |{ch_fail, w_err_nz};

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor: vector table plus hand sequences,
// expected outputs queued at drive time and compared after the clock edge.
module tb_pll_lock_monitor;

    localparam int unsigned NUM_CH       = 2;
    localparam int unsigned SYNC_STAGES  = 2;
    localparam int unsigned LOCK_TIMEOUT = 16;
    localparam int unsigned ERR_CNT_W    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pll_lock = 2'b00;
    logic [1:0] ch_en = 2'b00;
    logic       clr = 1'b0;
    logic [1:0] lock_sync, ch_locked, ch_fail;
    logic       all_locked, err_any;
    logic [5:0] err_cnt;

    pll_lock_monitor #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .ERR_CNT_W   (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .ch_en     (ch_en),
        .clr       (clr),
        .lock_sync (lock_sync),
        .ch_locked (ch_locked),
        .ch_fail   (ch_fail),
        .all_locked(all_locked),
        .err_any   (err_any),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] en;
        logic [1:0] lock;
        logic       clr;
        logic [1:0] sync;
        logic [1:0] lck;
        logic [1:0] fail;
        logic       all;
        logic       any;
        logic [2:0] c1;
        logic [2:0] c0;
    } vec_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    vec_t        sb_q[$];
    string       tag_q[$];
    vec_t        tbl[9];

    function automatic vec_t mk(input logic [1:0] en, input logic [1:0] lock, input logic c,
                                input logic [1:0] sync, input logic [1:0] lck,
                                input logic [1:0] fail, input logic all,
                                input logic [2:0] c1, input logic [2:0] c0);
        vec_t v;
        v.en = en; v.lock = lock; v.clr = c;
        v.sync = sync; v.lck = lck; v.fail = fail; v.all = all;
        v.c1 = c1; v.c0 = c0;
        v.any = (fail != 2'b00) || (c1 != 3'd0) || (c0 != 3'd0);
        return v;
    endfunction

    task automatic chk(input string tag, input string fld, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s: got %b expected %b", tag, fld, got, exp);
        end
    endtask

    task automatic cmp(input string tag, input vec_t v);
        chk(tag, "lock_sync",  {4'b0, lock_sync},  {4'b0, v.sync});
        chk(tag, "ch_locked",  {4'b0, ch_locked},  {4'b0, v.lck});
        chk(tag, "ch_fail",    {4'b0, ch_fail},    {4'b0, v.fail});
        chk(tag, "all_locked", {5'b0, all_locked}, {5'b0, v.all});
        chk(tag, "err_any",    {5'b0, err_any},    {5'b0, v.any});
        chk(tag, "err_cnt",    err_cnt,            {v.c1, v.c0});
    endtask

    task automatic apply(input string tag, input vec_t v);
        vec_t  e;
        string t;
        ch_en    = v.en;
        pll_lock = v.lock;
        clr      = v.clr;
        sb_q.push_back(v);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            cmp(t, e);
        end
    endtask

    initial begin
        vec_t zero;
        logic [2:0] c0p, c0n, c1v;
        logic [1:0] lk, sy;

        zero = mk(2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 3'd0);

        // Both channels enabled, lock rises after 5 cycles in WAIT
        for (int unsigned i = 0; i < 5; i++)
            tbl[i] = mk(2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 3'd0);
        tbl[5] = mk(2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 3'd0);
        tbl[6] = mk(2'b11, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 3'd0, 3'd0);
        tbl[7] = mk(2'b11, 2'b11, 1'b0, 2'b11, 2'b11, 2'b00, 1'b1, 3'd0, 3'd0);
        tbl[8] = mk(2'b11, 2'b11, 1'b0, 2'b11, 2'b11, 2'b00, 1'b1, 3'd0, 3'd0);

        // Reset held with active inputs: nothing moves
        ch_en = 2'b11; pll_lock = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_hold", zero);
        pll_lock = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 9; i++) apply("lock_both", tbl[i]);

        // ch0 drops 4 cycles and returns, 9 times; counter saturates at 7
        for (int unsigned r = 1; r <= 9; r++) begin
            c0p = (r - 1 > 7) ? 3'd7 : 3'(r - 1);
            c0n = (r > 7) ? 3'd7 : 3'(r);
            for (int unsigned s = 0; s < 7; s++) begin
                lk = (s < 2 || s == 6) ? 2'b11 : 2'b10;
                sy = (s == 0 || s >= 5) ? 2'b11 : 2'b10;
                apply("relock", mk(2'b11, (s < 4) ? 2'b10 : 2'b11, 1'b0, sy, lk, 2'b00,
                                   lk == 2'b11, 3'd0, (s < 2) ? c0p : c0n));
            end
        end

        // Disable ch0: goes idle, count held
        apply("dis0_a", mk(2'b10, 2'b10, 1'b0, 2'b11, 2'b10, 2'b00, 1'b1, 3'd0, 3'd7));
        apply("dis0_b", mk(2'b10, 2'b10, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 3'd0, 3'd7));
        apply("dis0_c", mk(2'b10, 2'b10, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 3'd0, 3'd7));

        // Re-enable ch0; rise reaches the FSM on the same cycle the timer expires
        for (int unsigned k = 0; k <= 16; k++) begin
            apply("rise_at_expiry", mk(2'b11, (k >= 14) ? 2'b11 : 2'b10, 1'b0,
                                       (k >= 15) ? 2'b11 : 2'b10,
                                       (k == 16) ? 2'b11 : 2'b10, 2'b00,
                                       k == 16, 3'd0, 3'd7));
        end

        // clr on the same cycle the fall is acted on
        apply("clrfall_a", mk(2'b11, 2'b10, 1'b0, 2'b11, 2'b11, 2'b00, 1'b1, 3'd0, 3'd7));
        apply("clrfall_b", mk(2'b11, 2'b10, 1'b0, 2'b10, 2'b11, 2'b00, 1'b1, 3'd0, 3'd7));
        apply("clrfall_c", mk(2'b11, 2'b10, 1'b1, 2'b10, 2'b10, 2'b00, 1'b0, 3'd0, 3'd0));
        apply("clrfall_d", mk(2'b11, 2'b10, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 3'd0, 3'd0));

        // Both idle, then ch0 alone with no lock times out
        apply("idle_a", mk(2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 3'd0, 3'd0));
        apply("idle_b", zero);
        apply("idle_c", zero);
        for (int unsigned w = 0; w <= 16; w++) begin
            apply("timeout0", mk(2'b01, 2'b00, 1'b0, 2'b00, 2'b00,
                                 (w == 16) ? 2'b01 : 2'b00, 1'b0, 3'd0,
                                 (w == 16) ? 3'd1 : 3'd0));
        end
        apply("fail_sticky_a", mk(2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 3'd0, 3'd1));
        apply("fail_sticky_b", mk(2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 3'd0, 3'd1));
        apply("fail_clr", mk(2'b01, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 3'd0));
        for (int unsigned v = 1; v <= 16; v++) begin
            apply("rewait0", mk(2'b01, 2'b00, 1'b0, 2'b00, 2'b00,
                                (v == 16) ? 2'b01 : 2'b00, 1'b0, 3'd0,
                                (v == 16) ? 3'd1 : 3'd0));
        end

        // ch1 fails three times via enable toggling; clr with ch_en=0 stays idle
        apply("clr_idle", mk(2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 3'd0));
        for (int unsigned r = 1; r <= 3; r++) begin
            apply("fail1_idle", mk(2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0,
                                   3'(r - 1), 3'd0));
            for (int unsigned j = 0; j <= 16; j++) begin
                c1v = (j == 16) ? 3'(r) : 3'(r - 1);
                apply("fail1", mk(2'b10, 2'b00, 1'b0, 2'b00, 2'b00,
                                  (j == 16) ? 2'b10 : 2'b00, 1'b0, c1v, 3'd0));
            end
        end

        // Asynchronous reset while ch1 is in FAIL with count 3
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        cmp("async_reset", zero);
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_mid", zero);
        rst_n = 1'b1;
        for (int unsigned v = 0; v <= 16; v++) begin
            apply("post_reset", mk(2'b10, 2'b00, 1'b0, 2'b00, 2'b00,
                                   (v == 16) ? 2'b10 : 2'b00, 1'b0,
                                   (v == 16) ? 3'd1 : 3'd0, 3'd0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 Parameter NUM_CH, default 2: number of monitored PLL lock inputs, legal 1..8.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth per channel, legal 2..4.
REQ-003 Parameter LOCK_TIMEOUT, default 1024: maximum cycles allowed to (re)lock, legal 2..65535.
REQ-004 Parameter ERR_CNT_W, default 3: width of each per-channel error counter, legal 2..8.
REQ-005 clk  in  1  monitor clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 pll_lock  in  NUM_CH  raw PLL lock flags, asynchronous to clk.
REQ-008 ch_en  in  NUM_CH  per-channel enable, synchronous.
REQ-009 clr  in  1  synchronous clear of fail states and error counters.
REQ-010 lock_sync  out  NUM_CH  synchronized pll_lock.
REQ-011 ch_locked  out  NUM_CH  channel state is LOCKED.
REQ-012 ch_fail  out  NUM_CH  channel state is FAIL.
REQ-013 all_locked  out  1  every enabled channel LOCKED and at least one channel enabled.
REQ-014 err_any  out  1  OR of ch_fail and of every nonzero err_cnt field.
REQ-015 err_cnt  out  NUM_CH*ERR_CNT_W  per-channel error counts; channel i at bits [i*ERR_CNT_W +: ERR_CNT_W].

Function
REQ-016 Each channel SHALL pass pll_lock[i] through a SYNC_STAGES flop chain; lock_sync[i] is the last stage, giving SYNC_STAGES cycles of latency.
REQ-017 Each channel SHALL register lock_sync[i] once more as prev; rise = lock_sync & ~prev, fall = ~lock_sync & prev.
REQ-018 Each channel SHALL run an independent FSM with states IDLE, WAIT, LOCKED, LOST, FAIL, and a timer of width clog2(LOCK_TIMEOUT+1).
REQ-019 IDLE: ch_en[i]=1 -> WAIT with timer=0; otherwise stay.
REQ-020 WAIT: rise -> LOCKED; else timer==LOCK_TIMEOUT-1 -> FAIL; else timer+1.
REQ-021 LOCKED: fall -> LOST with timer=0 and err_cnt+1.
REQ-022 LOST: rise -> LOCKED (relock); else timer==LOCK_TIMEOUT-1 -> FAIL; else timer+1.
REQ-023 Entry to FAIL SHALL increment err_cnt by 1; FAIL is sticky until clr or ch_en[i]=0.
REQ-024 ch_en[i]=0 in any state SHALL force IDLE and timer=0 next cycle; err_cnt holds.
REQ-025 clr=1 SHALL zero all err_cnt and move FAIL channels to WAIT with timer=0 (IDLE if ch_en[i]=0); clr overrides every same-cycle event, including increments.
REQ-026 Rise in the same cycle as timer expiry SHALL win (-> LOCKED, no error).
REQ-027 err_cnt SHALL saturate at 2^ERR_CNT_W-1 and never wrap.
REQ-028 ch_locked SHALL assert SYNC_STAGES+1 cycles after the first clk edge that samples pll_lock high.
REQ-029 A lock high pulse that vanishes before reaching lock_sync SHALL cause no state change; a pulse reaching lock_sync for at least 1 cycle SHALL be treated as a lock followed by a loss.
REQ-030 All outputs SHALL be registered or decoded directly from registered state; there is no combinational path from inputs to outputs.

Reset
REQ-031 With rst_n=0: sync chains, prev, timers and err_cnt are 0, FSMs are IDLE, and all outputs are 0 immediately, without waiting for clk.
REQ-032 After rst_n deasserts, the first active edge SHALL move enabled channels to WAIT.
REQ-033 Reset asserted mid-count or mid-FAIL SHALL discard all history.

Verification (NUM_CH=2, SYNC_STAGES=2, LOCK_TIMEOUT=16, ERR_CNT_W=3)
REQ-034 ch_en=2'b11, pll_lock rises on both channels 5 cycles after reset -> lock_sync 2 cycles later, ch_locked=2'b11 3 cycles later, all_locked=1, err_cnt=0.
REQ-035 ch_en=2'b01, pll_lock=0 -> ch_fail[0]=1 after 16 cycles in WAIT, err_cnt[0]=1, err_any=1; clr pulse -> ch_fail=0, err_cnt=0, WAIT.
REQ-036 Channel 0 locked, pll_lock[0] drops 4 cycles and returns -> LOST then LOCKED, err_cnt[0]=1, no FAIL; repeat 9 times -> err_cnt[0] saturates at 7.
REQ-037 pll_lock[0] rise arranged so that rise coincides with timer==15 -> LOCKED, ch_fail stays 0; clr asserted together with a fall -> err_cnt=0.
REQ-038 rst_n pulsed low while channel 1 is in FAIL with err_cnt=3 -> outputs 0 asynchronously; after release, WAIT with err_cnt=0.
